bsg_link_sdr_upstream_ctrl: RTL

Credit-based transmit controller for the SDR link: accepts words from the core on a valid/ready interface and drives the registered link data/valid outputs toward the off-chip output PHY. It sends only while it holds credits for the receiver's input FIFO, which sits behind the input SDR PHY. It replenishes credits from the token line that the receiver toggles back. It runs entirely in the core clock domain; the token line arrives here already synchronized.

---
 rtl/bsg_link_pkg.sv | 16 +
 rtl/bsg_link_credit_counter.sv | 47 ++++
 rtl/bsg_link_sdr_upstream_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/bsg_link_pkg.sv
// Shared definitions for the SDR link upstream controller and its credit counter.
package bsg_link_pkg;

    // Upstream controller state: held in S_RESET while reset_i is high,
    // S_ACTIVE once the first cycle with reset_i low has passed.
    typedef enum logic {
        S_RESET  = 1'b0,
        S_ACTIVE = 1'b1
    } link_state_e;

    // Credit counter width: must hold 0 .. 2^lg_fifo_depth inclusive.
    function automatic int credit_width(input int lg_fifo_depth);
        return lg_fifo_depth + 1;
    endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Saturating credit counter: resets to the receiver FIFO depth, counts down by
// one per send and up by R per token edge, clamping at the maximum and pulsing
// overflow_o in the cycle an update would have exceeded it.
module bsg_link_credit_counter
    import bsg_link_pkg::*;
#(
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 0,
    localparam int cw = credit_width(lg_fifo_depth_p)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          dec_i,
    input  logic          inc_i,
    output logic [cw-1:0] count_o,
    output logic          overflow_o
);

    // One extra bit so max + R can be represented before the clamp.
    typedef logic [cw:0] ext_t;

    localparam ext_t max_lp = ext_t'(2 ** lg_fifo_depth_p);
    localparam ext_t ret_lp = ext_t'(2 ** lg_credit_to_token_decimation_p);

    logic [cw-1:0] count_r;
    ext_t          sum;
    logic [cw-1:0] count_next;

    // Net update; a decrement only happens when count_r >= 1, so no underflow.
    always_comb begin
        sum        = {1'b0, count_r} - ext_t'(dec_i) + (inc_i ? ret_lp : '0);
        overflow_o = (sum > max_lp);
        count_next = overflow_o ? max_lp[cw-1:0] : sum[cw-1:0];
    end

    // Counter register; a fresh link holds the full receiver FIFO in credit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= max_lp[cw-1:0];
        end else begin
            count_r <= count_next;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/bsg_link_sdr_upstream_ctrl.sv
// Credit-based SDR link transmit controller. Accepts core words on a
// valid/ready port and drives registered link data/valid while credits for the
// receiver FIFO remain; credits come back as edges on the synchronized token line.
//
// Handshake: a word transfers in any cycle where v_i & ready_and_o. ready_and_o
// depends only on registered state and link_enable_i, never on v_i, and v_i
// may be raised or dropped freely by the core.
module bsg_link_sdr_upstream_ctrl
    import bsg_link_pkg::*;
#(
    // Link data width; instantiations are expected to set this explicitly.
    parameter int width_p                         = 16,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 0,
    localparam int cw = credit_width(lg_fifo_depth_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               link_enable_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] link_data_o,
    output logic               link_v_o,
    input  logic               token_i,
    output logic [cw-1:0]      credit_o,
    output logic               error_o
);

    link_state_e        state;
    logic               token_r;
    logic               link_v_r;
    logic [width_p-1:0] link_data_r;
    logic               error_r;

    logic               send;
    logic               token_edge;
    logic               overflow;
    logic [cw-1:0]      credit;

    // Sending is allowed only when active, enabled and holding at least one credit.
    always_comb begin
        ready_and_o = (state == S_ACTIVE) & link_enable_i & (credit != '0);
        send        = v_i & ready_and_o;
        token_edge  = token_i ^ token_r;
    end

    bsg_link_credit_counter #(
        .lg_fifo_depth_p                 (lg_fifo_depth_p),
        .lg_credit_to_token_decimation_p (lg_credit_to_token_decimation_p)
    ) credit_counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .dec_i      (send),
        .inc_i      (token_edge),
        .count_o    (credit),
        .overflow_o (overflow)
    );

    // FSM, token edge history, link output registers and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= S_RESET;
            token_r     <= 1'b0;
            link_v_r    <= 1'b0;
            link_data_r <= '0;
            error_r     <= 1'b0;
        end else begin
            case (state)
                S_RESET:  state <= S_ACTIVE;
                S_ACTIVE: state <= S_ACTIVE;
                default:  state <= S_RESET;
            endcase
            token_r  <= token_i;
            link_v_r <= send;
            // Hold the last word when idle so the pads do not toggle.
            if (send) begin
                link_data_r <= data_i;
            end
            if (overflow) begin
                error_r <= 1'b1;
            end
        end
    end

    assign link_v_o    = link_v_r;
    assign link_data_o = link_data_r;
    assign credit_o    = credit;
    assign error_o     = error_r;

endmodule
